// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache with flushable fill
module icache #(
    parameter int INDEX_WIDTH = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int INST_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_busy,
    output logic                  inst_rdy,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rdy,
    input  logic [INST_WIDTH-1:0] mem_inst,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [INST_WIDTH-1:0]  r_data [LINES];

    logic [INDEX_WIDTH-1:0] r_fill_idx;
    logic [TAG_W-1:0]       r_fill_tag;

    logic [INDEX_WIDTH-1:0] w_req_idx;
    logic [TAG_W-1:0]       w_req_tag;
    logic                   w_hit;
    logic                   w_do_hit;
    logic                   w_do_miss;
    logic                   w_do_fill;
    logic                   w_do_resp;
    logic                   w_unused;

    assign w_req_idx = if_pc[INDEX_WIDTH+1:2];
    assign w_req_tag = if_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign w_hit     = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign if_busy   = (r_state != S_IDLE);
    assign w_unused  = &{1'b0, if_pc[1:0]};

    // Next-state and per-cycle action decode; flush overrides every action
    always_comb begin
        w_next_state = r_state;
        w_do_hit     = 1'b0;
        w_do_miss    = 1'b0;
        w_do_fill    = 1'b0;
        w_do_resp    = 1'b0;
        if (flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (if_req) begin
                        if (w_hit) begin
                            w_do_hit = 1'b1;
                        end else begin
                            w_do_miss    = 1'b1;
                            w_next_state = S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_rdy) begin
                        w_do_fill    = 1'b1;
                        w_next_state = S_RESP;
                    end
                end
                S_RESP: begin
                    w_do_resp    = 1'b1;
                    w_next_state = S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // State register; frozen while rdy_in is low
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_next_state;
        end
    end

    // Control registers, outputs, valid bits and counters
    always_ff @(posedge clk) begin
        if (rst_in) begin
            inst_rdy   <= 1'b0;
            inst_out   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            r_valid    <= '0;
            r_fill_idx <= '0;
            r_fill_tag <= '0;
        end else if (rdy_in) begin
            inst_rdy <= w_do_hit | w_do_resp;
            if (w_do_hit) begin
                inst_out <= r_data[w_req_idx];
                hit_cnt  <= hit_cnt + 32'd1;
            end
            if (w_do_resp) begin
                inst_out <= r_data[r_fill_idx];
            end
            if (w_do_miss) begin
                mem_req    <= 1'b1;
                mem_addr   <= {if_pc[ADDR_WIDTH-1:2], 2'b00};
                r_fill_idx <= w_req_idx;
                r_fill_tag <= w_req_tag;
                miss_cnt   <= miss_cnt + 32'd1;
            end
            if (flush || w_do_fill) begin
                mem_req <= 1'b0;
            end
            if (w_do_fill) begin
                r_valid[r_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data array write on an accepted fill word; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (!rst_in && rdy_in && w_do_fill) begin
            r_tag[r_fill_idx]  <= r_fill_tag;
            r_data[r_fill_idx] <= mem_inst;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a line-level model
module tb_icache;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_busy;
    logic        inst_rdy;
    logic [31:0] inst_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_inst;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache #(.INDEX_WIDTH(4), .ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .if_req   (if_req),
        .if_pc    (if_pc),
        .if_busy  (if_busy),
        .inst_rdy (inst_rdy),
        .inst_out (inst_out),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdy  (mem_rdy),
        .mem_inst (mem_inst),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each line holds, plus request tallies
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [31:0] m_hits;
    logic [31:0] m_miss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
    endfunction

    task automatic model_install(input logic [31:0] pc, input logic [31:0] word);
        m_valid[pc[5:2]] = 1'b1;
        m_tag[pc[5:2]]   = pc[31:6];
        m_data[pc[5:2]]  = word;
    endtask

    task automatic check_counters();
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_miss);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
        check("rst_inst_rdy", {31'd0, inst_rdy}, 32'd0);
        check("rst_inst_out", inst_out, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_busy", {31'd0, if_busy}, 32'd0);
        check_counters();
    endtask

    // fmode: 0 normal fill, 1 flush before mem_rdy, 2 flush with mem_rdy, 3 flush during response
    task automatic access(input logic [31:0] pc, input logic [31:0] word,
                          input int mdelay, input int fmode, input bit stall);
        bit hit;
        logic [31:0] aligned;
        hit     = model_hit(pc);
        aligned = {pc[31:2], 2'b00};
        @(negedge clk);
        if_req = 1'b1;
        if_pc  = pc;
        @(negedge clk);
        if_req = 1'b0;
        if_pc  = $urandom;
        if (hit) begin
            m_hits++;
            check("hit_rdy", {31'd0, inst_rdy}, 32'd1);
            check("hit_data", inst_out, m_data[pc[5:2]]);
            check("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
            check("hit_busy", {31'd0, if_busy}, 32'd0);
        end else begin
            m_miss++;
            check("miss_req", {31'd0, mem_req}, 32'd1);
            check("miss_addr", mem_addr, aligned);
            check("miss_busy", {31'd0, if_busy}, 32'd1);
            check("miss_no_rdy", {31'd0, inst_rdy}, 32'd0);
            if (stall) begin
                rdy_in   = 1'b0;
                mem_rdy  = 1'b1;
                mem_inst = $urandom;
                flush    = 1'($urandom_range(0, 1));
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_req", {31'd0, mem_req}, 32'd1);
                    check("stall_busy", {31'd0, if_busy}, 32'd1);
                    check("stall_no_rdy", {31'd0, inst_rdy}, 32'd0);
                end
                rdy_in  = 1'b1;
                mem_rdy = 1'b0;
                flush   = 1'b0;
            end
            for (int i = 0; i < mdelay; i++) begin
                @(negedge clk);
                check("fill_req_held", {31'd0, mem_req}, 32'd1);
                check("fill_addr_held", mem_addr, aligned);
                check("fill_no_rdy", {31'd0, inst_rdy}, 32'd0);
            end
            case (fmode)
                1: begin
                    flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                    check("flush_req_drop", {31'd0, mem_req}, 32'd0);
                    check("flush_idle", {31'd0, if_busy}, 32'd0);
                    check("flush_no_rdy", {31'd0, inst_rdy}, 32'd0);
                    mem_rdy  = 1'b1;
                    mem_inst = word;
                    @(negedge clk);
                    mem_rdy = 1'b0;
                    check("late_rdy_idle", {31'd0, if_busy}, 32'd0);
                    check("late_rdy_no_rdy", {31'd0, inst_rdy}, 32'd0);
                end
                2: begin
                    flush    = 1'b1;
                    mem_rdy  = 1'b1;
                    mem_inst = word;
                    @(negedge clk);
                    flush   = 1'b0;
                    mem_rdy = 1'b0;
                    check("coflush_req", {31'd0, mem_req}, 32'd0);
                    check("coflush_idle", {31'd0, if_busy}, 32'd0);
                    check("coflush_no_rdy", {31'd0, inst_rdy}, 32'd0);
                    @(negedge clk);
                    check("coflush_no_rdy2", {31'd0, inst_rdy}, 32'd0);
                end
                3: begin
                    mem_rdy  = 1'b1;
                    mem_inst = word;
                    @(negedge clk);
                    mem_rdy = 1'b0;
                    flush   = 1'b1;
                    model_install(pc, word);
                    check("resp_busy", {31'd0, if_busy}, 32'd1);
                    @(negedge clk);
                    flush = 1'b0;
                    check("respflush_no_rdy", {31'd0, inst_rdy}, 32'd0);
                    check("respflush_idle", {31'd0, if_busy}, 32'd0);
                end
                default: begin
                    mem_rdy  = 1'b1;
                    mem_inst = word;
                    @(negedge clk);
                    mem_rdy  = 1'b0;
                    mem_inst = $urandom;
                    model_install(pc, word);
                    check("resp_req_drop", {31'd0, mem_req}, 32'd0);
                    check("resp_busy", {31'd0, if_busy}, 32'd1);
                    check("resp_not_yet", {31'd0, inst_rdy}, 32'd0);
                    @(negedge clk);
                    check("fill_rdy", {31'd0, inst_rdy}, 32'd1);
                    check("fill_data", inst_out, word);
                    check("fill_idle", {31'd0, if_busy}, 32'd0);
                    @(negedge clk);
                    check("fill_pulse_end", {31'd0, inst_rdy}, 32'd0);
                end
            endcase
        end
        check_counters();
    endtask

    // Two hits on consecutive cycles; caller guarantees both lines are resident
    task automatic hit_pair(input logic [31:0] pc1, input logic [31:0] pc2);
        @(negedge clk);
        if_req = 1'b1;
        if_pc  = pc1;
        @(negedge clk);
        if_pc  = pc2;
        check("pair_rdy1", {31'd0, inst_rdy}, 32'd1);
        check("pair_data1", inst_out, m_data[pc1[5:2]]);
        @(negedge clk);
        if_req = 1'b0;
        check("pair_rdy2", {31'd0, inst_rdy}, 32'd1);
        check("pair_data2", inst_out, m_data[pc2[5:2]]);
        m_hits += 2;
        check_counters();
    endtask

    // Request presented together with flush must vanish without being counted
    task automatic dropped_req(input logic [31:0] pc);
        @(negedge clk);
        if_req = 1'b1;
        if_pc  = pc;
        flush  = 1'b1;
        @(negedge clk);
        if_req = 1'b0;
        flush  = 1'b0;
        check("drop_idle", {31'd0, if_busy}, 32'd0);
        check("drop_no_rdy", {31'd0, inst_rdy}, 32'd0);
        check("drop_no_req", {31'd0, mem_req}, 32'd0);
        check_counters();
    endtask

    task automatic reset_mid_fill(input logic [31:0] pc);
        @(negedge clk);
        if_req = 1'b1;
        if_pc  = pc;
        @(negedge clk);
        if_req = 1'b0;
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        do_reset();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) pc = pc | 32'h0001_0000;
        return pc;
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] pc2;
        int          op;
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        flush    = 1'b0;
        if_req   = 1'b0;
        if_pc    = '0;
        mem_rdy  = 1'b0;
        mem_inst = '0;
        m_hits   = 0;
        m_miss   = 0;

        do_reset();
        access(32'h0000_1004, 32'h00A0_0093, 2, 0, 1'b0);
        access(32'h0000_1006, 32'h0, 0, 0, 1'b0);
        hit_pair(32'h0000_1004, 32'h0000_1004);
        access(32'h0000_1044, 32'h1234_5678, 1, 0, 1'b0);
        access(32'h0000_1004, 32'h00A0_0093, 0, 0, 1'b0);
        check("conflict_miss_cnt", miss_cnt, 32'd3);
        access(32'h0000_2000, 32'hDEAD_BEEF, 2, 1, 1'b0);
        access(32'h0000_2000, 32'hCAFE_F00D, 0, 2, 1'b0);
        access(32'h0000_2000, 32'h0BAD_F00D, 0, 0, 1'b0);
        dropped_req(32'h0000_3000);
        access(32'h0000_3000, 32'h5555_AAAA, 1, 0, 1'b1);
        reset_mid_fill(32'h0000_4000);
        access(32'h0000_1004, 32'h00A0_0093, 0, 0, 1'b0);
        check("post_rst_miss_cnt", miss_cnt, 32'd1);

        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 19);
            pc = rand_pc();
            if (op == 0) begin
                dropped_req(pc);
            end else if (op == 1) begin
                pc2 = rand_pc();
                if (model_hit(pc) && model_hit(pc2)) hit_pair(pc, pc2);
                else access(pc, $urandom, $urandom_range(0, 3), 0, 1'b0);
            end else if (op == 2) begin
                access(pc, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), 1'b0);
            end else if (op == 3) begin
                access(pc, $urandom, $urandom_range(0, 2), 0, 1'b1);
            end else begin
                access(pc, $urandom, $urandom_range(0, 3), 0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
